mc_control: RTL and testbench
=============================

Name: mc_control

Overview:
- Multicycle control FSM for the MIPS CPU core. It sequences fetch, decode, execute, memory and writeback.
- It consumes the opcode/funct fields produced by the instruction decoder and drives every datapath control strobe: PC, IR, memory, register file, ALU muxes, ALU op.
- It stalls on a memory ready handshake and counts retired instructions.

Parameters:
- RETIRE_W, 32, width of the retired-instruction counter.
- HALT_ON_ILLEGAL, 0, if 1 an illegal opcode/funct parks the FSM in HALT until reset; if 0 it is skipped.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  6  instruction[31:26] from the decoder.
- funct  in  6  instruction[5:0] from the decoder.
- zero  in  1  ALU zero flag, sampled in BRANCH.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d, reg_write, reg_dst, mem_to_reg, alu_src_a  out  1 each  datapath strobes.
- pc_src  out  2  0=ALU result, 1=ALUOut (branch target), 2=jump {pc[31:28],addr,2'b00}.
- alu_src_b  out  2  0=regB, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2.
- alu_op  out  4  0 add, 1 sub, 2 and, 3 or, 4 slt, 5 sll.
- state  out  4  current state encoding, for debug.
- illegal  out  1  one-cycle pulse on unsupported opcode/funct.
- retired  out  RETIRE_W  count of completed instructions.

Behaviour:
- Reset (async, immediate): state=FETCH, retired=0, all strobes 0, pc_src=0, alu_src_b=0, alu_op=0, illegal=0.
- All control outputs are Moore (a function of state, plus latched class/opcode). Exception: pc_write in FETCH and BRANCH is qualified as described below.
- Supported opcodes:
  - R-type 000000, with funct add 100000, sub 100010, and 100100, or 100101, slt 101010, sll 000000.
  - addi 001000, lw 100011, sw 101011, beq 000100, j 000010.
- States: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_R=7, WB_I=8, WB_MEM=9, BRANCH=10, JUMP=11, HALT=15.
- FETCH:
  - Strobes: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=add.
  - While mem_ready=0: stay in FETCH; ir_write=0, pc_write=0.
  - On mem_ready=1: ir_write=1, pc_write=1 (PC+4), go to DECODE.
- DECODE:
  - Strobes: alu_src_a=0, alu_src_b=3, alu_op=add (branch target into ALUOut).
  - Opcode/funct are sampled this cycle and latched internally.
  - Dispatch: R-type→EXEC_R, addi→EXEC_I, lw/sw→MEM_ADDR, beq→BRANCH, j→JUMP.
  - Unsupported opcode, or R-type with unsupported funct: illegal pulses, then next state is HALT if HALT_ON_ILLEGAL=1, else FETCH. No retire.
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op from latched funct → WB_R.
- EXEC_I: alu_src_a=1, alu_src_b=2, alu_op=add → WB_I.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=add → MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_read=1, i_or_d=1; hold while mem_ready=0; → WB_MEM on mem_ready.
- MEM_WR: mem_write=1, i_or_d=1; hold while mem_ready=0; on mem_ready retire, → FETCH.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0; retire, → FETCH.
- WB_I: reg_write=1, reg_dst=0, mem_to_reg=0; retire, → FETCH.
- WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1; retire, → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=sub, pc_write_cond=1, pc_src=1. PC loads iff zero=1. Retire, → FETCH.
- JUMP: pc_write=1, pc_src=2; retire, → FETCH.
- HALT: all strobes 0; stays until reset.
- Retire: retired increments by 1 on the retiring cycle and wraps modulo 2^RETIRE_W.
- Latency with mem_ready tied 1 (cycles FETCH→back in FETCH): R=4, addi=4, lw=5, sw=4, beq=3, j=3.
- Each cycle of mem_ready=0 in FETCH, MEM_RD or MEM_WR adds exactly one cycle. mem_ready is ignored in all other states.
- mem_read and mem_write are never both 1. reg_write and mem_write are never both 1.
- Reset asserted mid-instruction: FSM returns to FETCH immediately and all strobes drop in the same cycle. A partially executed instruction is not retired.

Test Plan:
- R add (opcode 0, funct 100000), mem_ready=1 → states 0,1,2,7,0; reg_write=1 and reg_dst=1 only in WB_R; retired 0→1.
- lw (100011) with mem_ready held low 3 cycles in MEM_RD → state stays 5 for 4 cycles, mem_read=1 and i_or_d=1 throughout; total latency 8; mem_to_reg=1 in WB_MEM.
- beq with zero=1, then beq with zero=0 → both take 3 cycles; pc_write_cond=1 and pc_src=1 in BRANCH both times; retired +2.
- j (000010) → JUMP asserts pc_write=1, pc_src=2; next state FETCH.
- opcode 111111, run once with HALT_ON_ILLEGAL=0 and once with 1 → illegal pulses in DECODE; param 0: back to FETCH with retired unchanged; param 1: state=15 sticks until reset.
- reset asserted during MEM_WR while mem_ready=0 → state=0 and mem_write=0 without waiting for a clock edge; retired unchanged.

Source files
------------

// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
// Module      : mc_control
// Description : Multicycle control FSM for the MIPS core. Sequences fetch,
//               decode, execute, memory access and writeback, stalls on the
//               memory ready handshake and counts retired instructions.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-high reset
//   opcode         in   instruction[31:26] from the decoder
//   funct          in   instruction[5:0] from the decoder
//   zero           in   ALU zero flag, used in BRANCH
//   mem_ready      in   memory completes the current access this cycle
//   pc_write       out  PC load (qualified by mem_ready in FETCH, zero in BRANCH)
//   pc_write_cond  out  conditional PC load for beq
//   ir_write       out  instruction register load
//   mem_read       out  memory read strobe
//   mem_write      out  memory write strobe
//   i_or_d         out  memory address select: 0 = PC, 1 = ALUOut
//   reg_write      out  register file write enable
//   reg_dst        out  destination select: 0 = rt, 1 = rd
//   mem_to_reg     out  writeback select: 0 = ALUOut, 1 = MDR
//   alu_src_a      out  ALU A select: 0 = PC, 1 = regA
//   pc_src         out  0 = ALU result, 1 = ALUOut, 2 = jump target
//   alu_src_b      out  0 = regB, 1 = 4, 2 = sext imm, 3 = sext imm << 2
//   alu_op         out  0 add, 1 sub, 2 and, 3 or, 4 slt, 5 sll
//   state          out  current state encoding (debug)
//   illegal        out  one-cycle pulse on unsupported opcode/funct
//   retired        out  retired instruction count (wraps)
// ============================================================================
module mc_control #(
  parameter int RETIRE_W        = 32,  // must be >= 2
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                ir_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                i_or_d,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          pc_src,
  output logic [1:0]          alu_src_b,
  output logic [3:0]          alu_op,
  output logic [3:0]          state,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_R     = 4'd7,
    S_WB_I     = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd15
  } state_t;

  // Opcodes
  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_j     = 6'b000010;

  // R-type functs
  localparam logic [5:0] c_fn_add = 6'b100000;
  localparam logic [5:0] c_fn_sub = 6'b100010;
  localparam logic [5:0] c_fn_and = 6'b100100;
  localparam logic [5:0] c_fn_or  = 6'b100101;
  localparam logic [5:0] c_fn_slt = 6'b101010;
  localparam logic [5:0] c_fn_sll = 6'b000000;

  // ALU operation codes
  localparam logic [3:0] c_alu_add = 4'd0;
  localparam logic [3:0] c_alu_sub = 4'd1;
  localparam logic [3:0] c_alu_and = 4'd2;
  localparam logic [3:0] c_alu_or  = 4'd3;
  localparam logic [3:0] c_alu_slt = 4'd4;
  localparam logic [3:0] c_alu_sll = 4'd5;

  localparam logic [RETIRE_W-1:0] c_retire_one = {{(RETIRE_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  logic [5:0]          r_opcode;
  logic [5:0]          r_funct;
  logic [RETIRE_W-1:0] r_retired;

  logic w_funct_ok;
  logic w_legal;
  logic w_retire;

  // ALU op selected by the R-type funct field
  function automatic logic [3:0] funct_to_alu(input logic [5:0] fn);
    logic [3:0] op;
    op = c_alu_add;
    case (fn)
      c_fn_add: op = c_alu_add;
      c_fn_sub: op = c_alu_sub;
      c_fn_and: op = c_alu_and;
      c_fn_or:  op = c_alu_or;
      c_fn_slt: op = c_alu_slt;
      c_fn_sll: op = c_alu_sll;
      default:  op = c_alu_add;
    endcase
    return op;
  endfunction

  // Legality is judged on the live decoder fields during DECODE
  always_comb begin
    w_funct_ok = 1'b0;
    case (funct)
      c_fn_add, c_fn_sub, c_fn_and, c_fn_or, c_fn_slt, c_fn_sll: w_funct_ok = 1'b1;
      default: w_funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_legal = 1'b0;
    case (opcode)
      c_op_rtype: w_legal = w_funct_ok;
      c_op_addi, c_op_lw, c_op_sw, c_op_beq, c_op_j: w_legal = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  // An instruction retires on its final cycle; a store only once memory accepts it
  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: w_retire = 1'b1;
      S_MEM_WR: w_retire = mem_ready;
      default: w_retire = 1'b0;
    endcase
  end

  // State register, latched instruction fields and retire counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_opcode  <= 6'd0;
      r_funct   <= 6'd0;
      r_retired <= '0;
    end else begin
      if (w_retire) begin
        r_retired <= r_retired + c_retire_one;
      end
      case (r_state)
        S_FETCH: begin
          if (mem_ready) r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_opcode <= opcode;
          r_funct  <= funct;
          if (!w_legal) begin
            r_state <= HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
          end else begin
            case (opcode)
              c_op_rtype:     r_state <= S_EXEC_R;
              c_op_addi:      r_state <= S_EXEC_I;
              c_op_lw, c_op_sw: r_state <= S_MEM_ADDR;
              c_op_beq:       r_state <= S_BRANCH;
              c_op_j:         r_state <= S_JUMP;
              default:        r_state <= S_FETCH;
            endcase
          end
        end
        S_EXEC_R:   r_state <= S_WB_R;
        S_EXEC_I:   r_state <= S_WB_I;
        S_MEM_ADDR: r_state <= (r_opcode == c_op_lw) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD: begin
          if (mem_ready) r_state <= S_WB_MEM;
        end
        S_MEM_WR: begin
          if (mem_ready) r_state <= S_FETCH;
        end
        S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: r_state <= S_FETCH;
        S_HALT:   r_state <= S_HALT;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  // Control strobes decoded from the state register. Reset gates them off
  // directly so they drop at once even though FETCH would assert mem_read.
  // pc_write/ir_write in FETCH and pc_write in BRANCH are the only strobes
  // that look at a live input.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    pc_src        = 2'd0;
    alu_src_b     = 2'd0;
    alu_op        = c_alu_add;
    illegal       = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'd1;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = 2'd3;
          illegal   = ~w_legal;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = funct_to_alu(r_funct);
        end
        S_EXEC_I, S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_WB_R: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_WB_I: begin
          reg_write = 1'b1;
        end
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = c_alu_sub;
          pc_write_cond = 1'b1;
          pc_write      = zero;
          pc_src        = 2'd1;
        end
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = 2'd2;
        end
        default: begin
        end
      endcase
    end
  end

  assign state   = r_state;
  assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_control
// Description : Self-checking bench for mc_control. Two instances share the
//               stimulus: one continues past illegal instructions with a
//               32-bit counter, the other halts on them with a 2-bit counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_control;

  typedef struct packed {
    logic [3:0]  st;
    logic [9:0]  str;  // pc_write,pc_write_cond,ir_write,mem_read,mem_write,i_or_d,reg_write,reg_dst,mem_to_reg,alu_src_a
    logic [1:0]  pcs;
    logic [1:0]  asb;
    logic [3:0]  aop;
    logic        ill;
    logic [31:0] ret;
  } exp_t;

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic [3:0]  sf;   // mem_ready=0 cycles in FETCH
    logic [3:0]  sm;   // mem_ready=0 cycles in MEM_RD/MEM_WR
    logic [3:0]  n;    // ideal number of states
    logic [31:0] seq;  // state sequence, nibble 0 first
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic       a_pw, a_pwc, a_irw, a_mr, a_mw, a_iod, a_rw, a_rd, a_m2r, a_asa, a_ill;
  logic [1:0] a_pcs, a_asb;
  logic [3:0] a_aop, a_st;
  logic [31:0] a_ret;

  logic       b_pw, b_pwc, b_irw, b_mr, b_mw, b_iod, b_rw, b_rd, b_m2r, b_asa, b_ill;
  logic [1:0] b_pcs, b_asb;
  logic [3:0] b_aop, b_st;
  logic [1:0] b_ret;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] ret_exp = 0;
  exp_t sb[$];
  vec_t vecs[14];

  always #5 clk = ~clk;

  mc_control #(.RETIRE_W(32), .HALT_ON_ILLEGAL(1'b0)) dut0 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(a_pw), .pc_write_cond(a_pwc), .ir_write(a_irw),
    .mem_read(a_mr), .mem_write(a_mw), .i_or_d(a_iod), .reg_write(a_rw),
    .reg_dst(a_rd), .mem_to_reg(a_m2r), .alu_src_a(a_asa), .pc_src(a_pcs),
    .alu_src_b(a_asb), .alu_op(a_aop), .state(a_st), .illegal(a_ill), .retired(a_ret)
  );

  mc_control #(.RETIRE_W(2), .HALT_ON_ILLEGAL(1'b1)) dut1 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(b_pw), .pc_write_cond(b_pwc), .ir_write(b_irw),
    .mem_read(b_mr), .mem_write(b_mw), .i_or_d(b_iod), .reg_write(b_rw),
    .reg_dst(b_rd), .mem_to_reg(b_m2r), .alu_src_a(b_asa), .pc_src(b_pcs),
    .alu_src_b(b_asb), .alu_op(b_aop), .state(b_st), .illegal(b_ill), .retired(b_ret)
  );

  function automatic exp_t act0();
    return {a_st, a_pw, a_pwc, a_irw, a_mr, a_mw, a_iod, a_rw, a_rd, a_m2r, a_asa,
            a_pcs, a_asb, a_aop, a_ill, a_ret};
  endfunction

  function automatic exp_t act1();
    return {b_st, b_pw, b_pwc, b_irw, b_mr, b_mw, b_iod, b_rw, b_rd, b_m2r, b_asa,
            b_pcs, b_asb, b_aop, b_ill, 30'd0, b_ret};
  endfunction

  function automatic logic [3:0] funct_op(input logic [5:0] fn);
    case (fn)
      6'h20:   return 4'd0;
      6'h22:   return 4'd1;
      6'h24:   return 4'd2;
      6'h25:   return 4'd3;
      6'h2a:   return 4'd4;
      6'h00:   return 4'd5;
      default: return 4'd0;
    endcase
  endfunction

  // Expected outputs for a state, straight from the state description table
  function automatic exp_t spec_out(input logic [3:0] st, input logic [5:0] fn,
                                    input logic z, input logic mr, input logic ill,
                                    input logic [31:0] ret);
    exp_t e;
    e = '0;
    e.st  = st;
    e.ret = ret;
    case (st)
      4'd0:  begin e.str = {mr, 1'b0, mr, 1'b1, 6'b0}; e.asb = 2'd1; end
      4'd1:  begin e.asb = 2'd3; e.ill = ill; end
      4'd2:  begin e.str = 10'b0000000001; e.aop = funct_op(fn); end
      4'd3:  begin e.str = 10'b0000000001; e.asb = 2'd2; end
      4'd4:  begin e.str = 10'b0000000001; e.asb = 2'd2; end
      4'd5:  e.str = 10'b0001010000;
      4'd6:  e.str = 10'b0000110000;
      4'd7:  e.str = 10'b0000001100;
      4'd8:  e.str = 10'b0000001000;
      4'd9:  e.str = 10'b0000001010;
      4'd10: begin e.str = {z, 1'b1, 7'b0, 1'b1}; e.pcs = 2'd1; e.aop = 4'd1; end
      4'd11: begin e.str = 10'b1000000000; e.pcs = 2'd2; end
      default: e.str = 10'b0;
    endcase
    return e;
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: actual %h required %h", name, $time, act, exp);
    end
  endtask

  // Runs one instruction from FETCH back to FETCH, one comparison per cycle.
  // After DECODE the decoder fields are scrambled so latched values are used.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int sf, input int sm, input int n,
                           input logic [31:0] seq, input logic ill);
    int   idx;
    int   rf;
    int   rm;
    logic [3:0] st;
    logic mr;
    exp_t e;
    idx = 0; rf = sf; rm = sm;
    while (idx < n) begin
      @(negedge clk);
      st = seq[4*idx +: 4];
      mr = 1'b1;
      if (st == 4'd0 && rf > 0) mr = 1'b0;
      if ((st == 4'd5 || st == 4'd6) && rm > 0) mr = 1'b0;
      opcode    = (idx >= 2) ? ~op : op;
      funct     = (idx >= 2) ? ~fn : fn;
      zero      = z;
      mem_ready = mr;
      sb.push_back(spec_out(st, fn, z, mr, ill, ret_exp));
      #1;
      e = sb.pop_front();
      check($sformatf("%s_c%0d", name, idx), act0(), e);
      if (st == 4'd7 || st == 4'd8 || st == 4'd9 || st == 4'd10 || st == 4'd11 ||
          (st == 4'd6 && mr))
        ret_exp++;
      if (!mr && st == 4'd0) rf--;
      else if (!mr) rm--;
      else idx++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b0;
    #1;
    ret_exp = 0;
    check("reset_dut0", act0(), '0);
    check("reset_dut1", act1(), '0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    exp_t e;
    vecs[0]  = '{op:6'h00, fn:6'h20, z:1'b0, sf:4'd0, sm:4'd0, n:4'd4, seq:32'h7210};
    vecs[1]  = '{op:6'h00, fn:6'h22, z:1'b0, sf:4'd0, sm:4'd0, n:4'd4, seq:32'h7210};
    vecs[2]  = '{op:6'h00, fn:6'h24, z:1'b0, sf:4'd0, sm:4'd0, n:4'd4, seq:32'h7210};
    vecs[3]  = '{op:6'h00, fn:6'h25, z:1'b1, sf:4'd0, sm:4'd0, n:4'd4, seq:32'h7210};
    vecs[4]  = '{op:6'h00, fn:6'h2a, z:1'b0, sf:4'd0, sm:4'd0, n:4'd4, seq:32'h7210};
    vecs[5]  = '{op:6'h00, fn:6'h00, z:1'b0, sf:4'd0, sm:4'd0, n:4'd4, seq:32'h7210};
    vecs[6]  = '{op:6'h08, fn:6'h11, z:1'b0, sf:4'd0, sm:4'd0, n:4'd4, seq:32'h8310};
    vecs[7]  = '{op:6'h23, fn:6'h05, z:1'b0, sf:4'd0, sm:4'd0, n:4'd5, seq:32'h95410};
    vecs[8]  = '{op:6'h2b, fn:6'h07, z:1'b0, sf:4'd0, sm:4'd0, n:4'd4, seq:32'h6410};
    vecs[9]  = '{op:6'h04, fn:6'h00, z:1'b1, sf:4'd0, sm:4'd0, n:4'd3, seq:32'hA10};
    vecs[10] = '{op:6'h04, fn:6'h00, z:1'b0, sf:4'd0, sm:4'd0, n:4'd3, seq:32'hA10};
    vecs[11] = '{op:6'h02, fn:6'h3f, z:1'b1, sf:4'd0, sm:4'd0, n:4'd3, seq:32'hB10};
    vecs[12] = '{op:6'h00, fn:6'h20, z:1'b0, sf:4'd2, sm:4'd0, n:4'd4, seq:32'h7210};
    vecs[13] = '{op:6'h2b, fn:6'h00, z:1'b0, sf:4'd0, sm:4'd1, n:4'd4, seq:32'h6410};

    do_reset();

    for (int i = 0; i < 14; i++)
      run_instr($sformatf("vec%0d", i), vecs[i].op, vecs[i].fn, vecs[i].z,
                int'(vecs[i].sf), int'(vecs[i].sm), int'(vecs[i].n), vecs[i].seq, 1'b0);

    // 14 retirements on a 2-bit counter wrap to 2
    e = '0;
    e.st = 4'd0; e.str = 10'b0001000000; e.asb = 2'd1; e.ret = {30'd0, ret_exp[1:0]};
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("wrap_dut1", act1(), e);

    // Illegal opcode: dut0 skips, dut1 parks in HALT
    run_instr("ill_op", 6'h3f, 6'h20, 1'b0, 0, 0, 2, 32'h10, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      check($sformatf("ill_skip_dut0_%0d", k), act0(),
            spec_out(4'd0, 6'd0, 1'b0, 1'b0, 1'b0, ret_exp));
      e = '0;
      e.st = 4'd15; e.ret = {30'd0, ret_exp[1:0]};
      check($sformatf("halt_dut1_%0d", k), act1(), e);
    end

    do_reset();

    // R-type with an unsupported funct, then normal execution resumes
    run_instr("ill_fn", 6'h00, 6'h01, 1'b0, 0, 0, 2, 32'h10, 1'b1);
    run_instr("after_ill", 6'h00, 6'h25, 1'b0, 0, 0, 4, 32'h7210, 1'b0);

    // lw with memory stalled three cycles in MEM_RD
    run_instr("lw_stall", 6'h23, 6'h00, 1'b0, 0, 3, 5, 32'h95410, 1'b0);

    do_reset();

    // Reset in the middle of a stalled store
    run_instr("sw_pre", 6'h2b, 6'h00, 1'b0, 0, 0, 3, 32'h410, 1'b0);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("sw_memwr", act0(), spec_out(4'd6, 6'h00, 1'b0, 1'b0, 1'b0, ret_exp));
    #2;
    reset = 1'b1;
    #1;
    check("sw_async_reset", act0(), '0);
    ret_exp = 0;
    @(negedge clk);
    reset = 1'b0;
    run_instr("post_reset_j", 6'h02, 6'h00, 1'b0, 0, 0, 3, 32'hB10, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
